// File: rtl/wb_arbiter_pkg.sv
// Shared types for the register-file write-back arbiter.
// Entry layout and FSM encoding used by the arbiter and its load queue.
package wb_arbiter_pkg;

  localparam int DW  = 32;
  localparam int RFW = 5;

  typedef enum logic {
    NORMAL,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [RFW-1:0] rd;
    logic [DW-1:0]  data;
  } entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of pending load write-backs.
// Also reports which live entries target a given register.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  entry_t            din,
  input  logic [RFW-1:0]    match_rd,
  output entry_t            head,
  output logic              full,
  output logic              empty,
  output logic [2:0]        count,
  output logic [QDEPTH-1:0] match
);

  // Storage is sized for the largest legal depth; pointers wrap at QDEPTH.
  localparam int SLOTS = 4;

  entry_t     mem [SLOTS];
  logic [3:0] vld;
  logic [1:0] wp;
  logic [1:0] rp;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'(QDEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      vld   <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        vld[wp] <= 1'b1;
        wp      <= nxt(wp);
      end
      if (pop) begin
        vld[rp] <= 1'b0;
        rp      <= nxt(rp);
      end
      count <= count + 3'(push) - 3'(pop);
    end
  end

  assign head  = mem[rp];
  assign full  = (count == 3'(QDEPTH));
  assign empty = (count == 3'd0);

  always_comb begin
    match = '0;
    for (int i = 0; i < QDEPTH; i++)
      match[i] = vld[i] && (mem[i].rd == match_rd);
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: in-order ALU results vs. queued load results.
// ALU wins in NORMAL unless it would overtake a queued write to the same reg.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DW     = wb_arbiter_pkg::DW,
  parameter int RFW    = wb_arbiter_pkg::RFW,
  parameter int QDEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           alu_valid,
  input  logic [RFW-1:0] alu_reg,
  input  logic [DW-1:0]  alu_data,
  output logic           alu_ready,
  input  logic           ld_valid,
  input  logic [RFW-1:0] ld_reg,
  input  logic [DW-1:0]  ld_data,
  output logic           ld_ready,
  output logic           rf_we,
  output logic [RFW-1:0] wreg,
  output logic [DW-1:0]  wdata,
  output logic [2:0]     q_count
);

  state_t            state;
  entry_t            head;
  logic              full;
  logic              empty;
  logic [QDEPTH-1:0] match;
  logic              conflict;
  logic              alu_grant;
  logic              push;
  logic              pop;
  logic [2:0]        cnt_nxt;

  wb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .din      ('{rd: ld_reg, data: ld_data}),
    .match_rd (alu_reg),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (q_count),
    .match    (match)
  );

  assign conflict  = (alu_reg != '0) && (|match);
  assign alu_ready = (state == NORMAL) && !conflict && !rst;
  assign ld_ready  = !full && !rst;
  assign alu_grant = alu_valid && alu_ready;
  // r0 loads are accepted but never take a queue slot.
  assign push      = ld_valid && ld_ready && (ld_reg != '0);
  assign pop       = !empty && !alu_grant && !rst;
  assign cnt_nxt   = q_count + 3'(push) - 3'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NORMAL;
      rf_we <= 1'b0;
      wreg  <= '0;
      wdata <= '0;
    end else begin
      if (alu_grant) begin
        rf_we <= (alu_reg != '0);
        wreg  <= alu_reg;
        wdata <= alu_data;
      end else if (pop) begin
        rf_we <= (head.rd != '0);
        wreg  <= head.rd;
        wdata <= head.data;
      end else begin
        rf_we <= 1'b0;
      end
      unique case (state)
        NORMAL: if (cnt_nxt == 3'(QDEPTH)) state <= DRAIN;
        DRAIN:  if (cnt_nxt == 3'd0) state <= NORMAL;
        default: state <= NORMAL;
      endcase
    end
  end

endmodule
